// File: rtl/day3_pack_sequencer_if.sv
// Byte-stream input handshake for the day-3 pack sequencer.
// The source drives data/valid/eof; the sequencer answers with ready.
interface day3_pack_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_eof;

    modport master (output in_valid, output in_data, output in_eof, input in_ready);
    modport slave  (input in_valid, input in_data, input in_eof, output in_ready);
endinterface

// File: rtl/day3_pack_sequencer.sv
// Buffers one ASCII battery pack per lane, then drives init / lock-step digit
// streaming into the max_joltager units and waits out the result latency.
module day3_pack_sequencer #(
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned MAX_PACK       = 128,
    parameter int unsigned RESULT_LATENCY = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    day3_pack_sequencer_if.slave  in_if,
    output logic                  init,
    output logic                  stream_en,
    output logic [3:0]            next_battery      [NUM_UNITS],
    output logic [7:0]            battery_pack_size [NUM_UNITS],
    output logic                  batch_done,
    output logic                  finished,
    output logic                  overflow
);
    localparam int unsigned LW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned IW = (MAX_PACK > 1) ? $clog2(MAX_PACK) : 1;
    localparam int unsigned DW = $clog2(RESULT_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, FILL, INIT, STREAM, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [7:0]      wr_ptr_q, wr_ptr_d;
    logic [7:0]      size_q [NUM_UNITS];
    logic [7:0]      size_d [NUM_UNITS];
    logic [7:0]      len_q, len_d;
    logic [7:0]      k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            eof_q, eof_d;
    logic            overflow_q, overflow_d;
    logic            in_ready_q, in_ready_d;
    logic            init_q, init_d;
    logic            stream_en_q, stream_en_d;
    logic            batch_done_q, batch_done_d;
    logic            finished_q, finished_d;
    logic [3:0]      nb_q [NUM_UNITS];
    logic [3:0]      nb_d [NUM_UNITS];
    logic [7:0]      pack_size_q [NUM_UNITS];
    logic [7:0]      pack_size_d [NUM_UNITS];

    logic [3:0]      pack_mem_q [NUM_UNITS][MAX_PACK];
    logic            mem_we;
    logic            is_digit;
    logic            close_line;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        wr_ptr_d    = wr_ptr_q;
        size_d      = size_q;
        len_d       = len_q;
        k_d         = k_q;
        drain_d     = drain_q;
        eof_d       = eof_q;
        overflow_d  = overflow_q;
        pack_size_d = pack_size_q;
        mem_we      = 1'b0;
        close_line  = 1'b0;
        is_digit    = (in_if.in_data >= 8'h30) && (in_if.in_data <= 8'h39);

        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (in_if.in_valid && in_ready_q) begin
                    if (is_digit) begin
                        if (wr_ptr_q == 8'(MAX_PACK)) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 8'd1;
                        end
                    end else if (in_if.in_data == 8'h0A && wr_ptr_q != '0) begin
                        close_line = 1'b1;
                    end
                    // eof closes an open line using the pointer after this byte
                    if (in_if.in_eof && wr_ptr_d != '0) close_line = 1'b1;
                    eof_d = eof_q | in_if.in_eof;
                    if (close_line) begin
                        size_d[lane_q] = wr_ptr_d;
                        wr_ptr_d       = '0;
                        lane_d         = lane_q + LW'(1);
                    end
                    if (close_line && lane_q == LW'(NUM_UNITS - 1)) begin
                        state_d = INIT;
                    end else if (in_if.in_eof) begin
                        state_d = (lane_q != '0 || close_line) ? INIT : DONE;
                    end
                end
            end
            INIT: begin
                len_d = '0;
                for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                    if (size_q[i] > len_d) len_d = size_q[i];
                end
                k_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (k_q == len_q - 8'd1) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(RESULT_LATENCY - 1)) begin
                    state_d  = eof_q ? DONE : FILL;
                    lane_d   = '0;
                    wr_ptr_d = '0;
                    size_d   = '{default: '0};
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: ;
        endcase

        // Outputs are registered from the next state so they align with it.
        in_ready_d   = (state_d == FILL);
        init_d       = (state_d == INIT);
        stream_en_d  = (state_d == STREAM);
        batch_done_d = (state_d == DRAIN) && (drain_d == DW'(RESULT_LATENCY - 1));
        finished_d   = (state_d == DONE);
        if (state_d == INIT) pack_size_d = size_d;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            nb_d[i] = '0;
            if (state_d == STREAM && k_d < size_q[i]) nb_d[i] = pack_mem_q[i][k_d[IW-1:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            wr_ptr_q     <= '0;
            size_q       <= '{default: '0};
            len_q        <= '0;
            k_q          <= '0;
            drain_q      <= '0;
            eof_q        <= 1'b0;
            overflow_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            init_q       <= 1'b0;
            stream_en_q  <= 1'b0;
            batch_done_q <= 1'b0;
            finished_q   <= 1'b0;
            nb_q         <= '{default: '0};
            pack_size_q  <= '{default: '0};
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            wr_ptr_q     <= wr_ptr_d;
            size_q       <= size_d;
            len_q        <= len_d;
            k_q          <= k_d;
            drain_q      <= drain_d;
            eof_q        <= eof_d;
            overflow_q   <= overflow_d;
            in_ready_q   <= in_ready_d;
            init_q       <= init_d;
            stream_en_q  <= stream_en_d;
            batch_done_q <= batch_done_d;
            finished_q   <= finished_d;
            nb_q         <= nb_d;
            pack_size_q  <= pack_size_d;
        end
    end

    // Digit storage needs no reset: reads are gated by the per-lane sizes.
    always_ff @(posedge clock) begin
        if (mem_we) pack_mem_q[lane_q][wr_ptr_q[IW-1:0]] <= in_if.in_data[3:0];
    end

    assign in_if.in_ready    = in_ready_q;
    assign init              = init_q;
    assign stream_en         = stream_en_q;
    assign next_battery      = nb_q;
    assign battery_pack_size = pack_size_q;
    assign batch_done        = batch_done_q;
    assign finished          = finished_q;
    assign overflow          = overflow_q;
endmodule

// File: tb/tb_day3_pack_sequencer.sv
// Scoreboard bench for day3_pack_sequencer: expected stream beats are queued
// per batch and popped by a negedge monitor; each scenario checks its own timing.
module tb_day3_pack_sequencer;
    localparam int NU = 2;
    localparam int MP = 4;
    localparam int RL = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    day3_pack_sequencer_if ifc();
    logic       init, stream_en, batch_done, finished, overflow;
    logic [3:0] next_battery      [NU];
    logic [7:0] battery_pack_size [NU];

    day3_pack_sequencer #(.NUM_UNITS(NU), .MAX_PACK(MP), .RESULT_LATENCY(RL)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_if             (ifc),
        .init              (init),
        .stream_en         (stream_en),
        .next_battery      (next_battery),
        .battery_pack_size (battery_pack_size),
        .batch_done        (batch_done),
        .finished          (finished),
        .overflow          (overflow)
    );

    typedef struct packed {logic [3:0] l0; logic [3:0] l1;} beat_t;
    beat_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int init_cnt = 0, stream_cnt = 0, done_cnt = 0;
    int init_cyc = 0, last_stream_cyc = 0;
    logic [7:0] init_sz0, init_sz1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        beat_t e;
        if (!reset) begin
            if (init) begin
                init_cnt++;
                init_cyc = cyc;
                init_sz0 = battery_pack_size[0];
                init_sz1 = battery_pack_size[1];
            end
            if (batch_done) done_cnt++;
            checks++;
            if (stream_en) begin
                stream_cnt++;
                last_stream_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_beat: got %0d,%0d but no beat expected", next_battery[0], next_battery[1]);
                end else begin
                    e = exp_q.pop_front();
                    if ({next_battery[0], next_battery[1]} !== e) begin
                        errors++;
                        $display("FAIL stream_beat: got %0d,%0d expected %0d,%0d",
                                 next_battery[0], next_battery[1], e.l0, e.l1);
                    end
                end
            end else if (next_battery[0] !== 4'd0 || next_battery[1] !== 4'd0) begin
                errors++;
                $display("FAIL idle_battery: got %0d,%0d expected 0,0", next_battery[0], next_battery[1]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic eof);
        int t = 0;
        while (ifc.in_ready !== 1'b1 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        ifc.in_eof   = eof;
        @(negedge clock);
        ifc.in_valid = 1'b0;
        ifc.in_eof   = 1'b0;
        ifc.in_data  = 8'h00;
    endtask

    task automatic send_str(input string s, input logic eof);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], eof && (i == s.len() - 1));
    endtask

    task automatic wait_batch_done(output int dcyc);
        int t = 0;
        dcyc = -1;
        while (t < 300) begin
            @(negedge clock);
            if (batch_done === 1'b1) begin
                dcyc = cyc;
                break;
            end
            t++;
        end
        if (dcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL batch_done_timeout: got none expected pulse");
        end
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        ifc.in_eof   = 1'b0;
        #1 reset = 1'b1;
        #11;
        checks++;
        if ({init, stream_en, batch_done, finished, overflow, ifc.in_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {init, stream_en, batch_done, finished, overflow, ifc.in_ready});
        end
        checks++;
        if ({battery_pack_size[0], battery_pack_size[1]} !== 16'h0) begin
            errors++;
            $display("FAIL reset_sizes: got %0d,%0d expected 0,0", battery_pack_size[0], battery_pack_size[1]);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_idle_cycle: got %b expected 0", ifc.in_ready);
        end
        @(negedge clock);
        checks++;
        if (ifc.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_idle: got %b expected 1", ifc.in_ready);
        end
    endtask

    task automatic test_basic();
        int ic, sc, acc, dc;
        ic = init_cnt;
        sc = stream_cnt;
        exp_q.push_back(beat_t'{4'd1, 4'd3});
        exp_q.push_back(beat_t'{4'd2, 4'd4});
        exp_q.push_back(beat_t'{4'd0, 4'd5});
        send_str("12\n345\n", 1'b0);
        acc = cyc;
        wait_batch_done(dc);
        checks++;
        if (init_cnt - ic !== 1 || init_cyc !== acc) begin
            errors++;
            $display("FAIL basic_init: got count %0d at cyc %0d expected 1 at cyc %0d", init_cnt - ic, init_cyc, acc);
        end
        checks++;
        if ({init_sz0, init_sz1} !== {8'd2, 8'd3}) begin
            errors++;
            $display("FAIL basic_sizes: got %0d,%0d expected 2,3", init_sz0, init_sz1);
        end
        checks++;
        if (stream_cnt - sc !== 3 || last_stream_cyc - init_cyc !== 3) begin
            errors++;
            $display("FAIL basic_stream_len: got %0d cycles ending %0d after init expected 3 and 3",
                     stream_cnt - sc, last_stream_cyc - init_cyc);
        end
        checks++;
        if (dc - last_stream_cyc !== RL) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d expected %0d", dc - last_stream_cyc, RL);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL basic_beats_left: got %0d expected 0", exp_q.size());
        end
        @(negedge clock);
        checks++;
        if (ifc.in_ready !== 1'b1 || battery_pack_size[1] !== 8'd3) begin
            errors++;
            $display("FAIL basic_after_done: got ready %b size1 %0d expected 1 and 3", ifc.in_ready, battery_pack_size[1]);
        end
    endtask

    task automatic test_blank_lines();
        int sc, dc;
        sc = stream_cnt;
        exp_q.push_back(beat_t'{4'd7, 4'd8});
        exp_q.push_back(beat_t'{4'd0, 4'd9});
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_str("\n7", 1'b0);
        send_byte(8'h0D, 1'b0);
        send_str("\n89\n", 1'b0);
        wait_batch_done(dc);
        checks++;
        if ({init_sz0, init_sz1} !== {8'd1, 8'd2}) begin
            errors++;
            $display("FAIL blank_sizes: got %0d,%0d expected 1,2", init_sz0, init_sz1);
        end
        checks++;
        if (stream_cnt - sc !== 2 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL blank_stream: got %0d cycles %0d left expected 2 and 0", stream_cnt - sc, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int sc, dc;
        sc = stream_cnt;
        exp_q.push_back(beat_t'{4'd1, 4'd7});
        exp_q.push_back(beat_t'{4'd2, 4'd0});
        exp_q.push_back(beat_t'{4'd3, 4'd0});
        exp_q.push_back(beat_t'{4'd4, 4'd0});
        send_str("123456\n7\n", 1'b0);
        wait_batch_done(dc);
        checks++;
        if ({init_sz0, init_sz1} !== {8'd4, 8'd1} || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_batch: got sizes %0d,%0d ovf %b expected 4,1 ovf 1", init_sz0, init_sz1, overflow);
        end
        checks++;
        if (stream_cnt - sc !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL overflow_stream: got %0d cycles %0d left expected 4 and 0", stream_cnt - sc, exp_q.size());
        end
        exp_q.push_back(beat_t'{4'd1, 4'd2});
        send_str("1\n2\n", 1'b0);
        wait_batch_done(dc);
        checks++;
        if ({init_sz0, init_sz1} !== {8'd1, 8'd1} || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got sizes %0d,%0d ovf %b expected 1,1 ovf 1", init_sz0, init_sz1, overflow);
        end
    endtask

    task automatic test_reset_midstream();
        int n = 0, t = 0, sc, dc;
        exp_q.push_back(beat_t'{4'd1, 4'd2});
        exp_q.push_back(beat_t'{4'd1, 4'd2});
        send_str("11\n22\n", 1'b0);
        while (n < 2 && t < 100) begin
            if (stream_en === 1'b1) n++;
            if (n < 2) begin
                @(negedge clock);
                t++;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL midstream_reach: got %0d stream cycles expected 2", n);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({stream_en, init, overflow, next_battery[0], next_battery[1]} !== 11'b0) begin
            errors++;
            $display("FAIL midstream_reset: got en %b init %b ovf %b nb %0d,%0d expected all 0",
                     stream_en, init, overflow, next_battery[0], next_battery[1]);
        end
        checks++;
        if ({battery_pack_size[0], battery_pack_size[1]} !== 16'h0) begin
            errors++;
            $display("FAIL midstream_sizes: got %0d,%0d expected 0,0", battery_pack_size[0], battery_pack_size[1]);
        end
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        sc = stream_cnt;
        exp_q.push_back(beat_t'{4'd5, 4'd6});
        send_str("5\n6\n", 1'b0);
        wait_batch_done(dc);
        checks++;
        if ({init_sz0, init_sz1} !== {8'd1, 8'd1} || stream_cnt - sc !== 1 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset_batch: got sizes %0d,%0d cycles %0d expected 1,1 and 1",
                     init_sz0, init_sz1, stream_cnt - sc);
        end
    endtask

    task automatic test_eof();
        int ic, sc, dc, stuck;
        ic = init_cnt;
        sc = stream_cnt;
        exp_q.push_back(beat_t'{4'd9, 4'd0});
        send_byte("9", 1'b1);
        wait_batch_done(dc);
        checks++;
        if ({init_sz0, init_sz1} !== {8'd1, 8'd0} || init_cnt - ic !== 1 || stream_cnt - sc !== 1) begin
            errors++;
            $display("FAIL eof_batch: got sizes %0d,%0d inits %0d cycles %0d expected 1,0 1 1",
                     init_sz0, init_sz1, init_cnt - ic, stream_cnt - sc);
        end
        stuck = 0;
        repeat (6) begin
            @(negedge clock);
            if (finished !== 1'b1 || ifc.in_ready !== 1'b0) stuck++;
        end
        checks++;
        if (stuck !== 0) begin
            errors++;
            $display("FAIL eof_finished: got %0d bad cycles (fin %b rdy %b) expected 0", stuck, finished, ifc.in_ready);
        end
    endtask

    task automatic test_eof_empty();
        int ic, dc0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL finished_cleared: got %b expected 0", finished);
        end
        ic  = init_cnt;
        dc0 = done_cnt;
        send_byte(8'h0A, 1'b1);
        checks++;
        if (finished !== 1'b1 || ifc.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_eof_finished: got fin %b rdy %b expected 1 0", finished, ifc.in_ready);
        end
        repeat (12) @(negedge clock);
        checks++;
        if (init_cnt !== ic || done_cnt !== dc0) begin
            errors++;
            $display("FAIL empty_eof_no_batch: got inits %0d dones %0d expected 0 0", init_cnt - ic, done_cnt - dc0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_blank_lines();
        test_overflow();
        test_reset_midstream();
        test_eof();
        test_eof_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
